// File: rtl/dac_spi_tx.sv
// Serial transmitter that shifts one DAC code per frame, MSB first, with CS framing.
// Optional macro DAC_SPI_CTRL_EN prepends CTRL_WORD and pads four zeros (16-bit frame).
module dac_spi_tx #(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] CTRL_WORD = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] dato_in,
  output logic       cs,
  output logic       sclk,
  output logic       sdo,
  output logic       busy,
  output logic       done,
  output logic [1:0] fsm_state
);

`ifdef DAC_SPI_CTRL_EN
  localparam int BITS = 16;
`else
  localparam int BITS = 8;
`endif
  localparam int         BCW      = $clog2(BITS);
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        div_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [BITS-1:0]   shreg;
  logic [BITS-1:0]   word;

  assign fsm_state = state;

`ifdef DAC_SPI_CTRL_EN
  always_comb begin
    word = {CTRL_WORD, dato_in, 4'b0000};
  end
`else
  always_comb begin
    word = dato_in;
  end
  if (CTRL_WORD != 4'b0000) begin : g_ctrl_word_unused
  end
`endif

  // Request protocol: start is a level request looked at only in IDLE; while the
  // FSM is elsewhere it is dropped, never queued. busy covers frame plus CS-high hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            state   <= SHIFT;
            cs      <= 1'b0;
            sclk    <= 1'b0;
            sdo     <= word[BITS-1];
            shreg   <= {word[BITS-2:0], 1'b0};
            bit_cnt <= BCW'(BITS - 1);
            div_cnt <= DIV_LOAD;
          end
        end
        SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: the only place sdo advances; zeros shift in so sdo
              // settles low once the last bit has been sampled.
              sclk  <= 1'b0;
              sdo   <= shreg[BITS-1];
              shreg <= {shreg[BITS-2:0], 1'b0};
              if (bit_cnt == '0) begin
                state <= TAIL;
              end else begin
                bit_cnt <= bit_cnt - BCW'(1);
              end
            end
          end
        end
        TAIL: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LOAD;
            cs      <= 1'b1;
            done    <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: lane 0 runs CLK_DIV=4, lane 1 runs CLK_DIV=1 (back-to-back frames).
module tb_dac_spi_tx;

`ifdef DAC_SPI_CTRL_EN
  localparam int BITS = 16;
`else
  localparam int BITS = 8;
`endif
  localparam logic [3:0] CTRL = 4'b0011;

  logic       clk;
  logic       rst_n_s [2];
  logic       start_s [2];
  logic [7:0] dato_s  [2];
  logic       cs_s    [2];
  logic       sclk_s  [2];
  logic       sdo_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [1:0] state_s [2];

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar i = 0; i < 2; i++) begin : g_lane
    dac_spi_tx #(.CLK_DIV(i == 0 ? 4 : 1), .CTRL_WORD(CTRL)) u_dut (
      .clk(clk), .reset_n(rst_n_s[i]), .start(start_s[i]), .dato_in(dato_s[i]),
      .cs(cs_s[i]), .sclk(sclk_s[i]), .sdo(sdo_s[i]), .busy(busy_s[i]),
      .done(done_s[i]), .fsm_state(state_s[i])
    );

    // Observer: bits at sclk rises, run lengths of cs/busy, done pulses, sdo stability.
    logic p_cs = 1'b1, p_sclk = 1'b0, p_sdo = 1'b0, p_busy = 1'b0;
    int low_run = 0, high_run = 0, busy_run = 0, pulse_run = 0;
    int last_cs_low = 0, last_cs_high = 0, last_busy = 0, last_pulses = 0;
    int frames = 0, done_cnt = 0, done_ok = 0, sdo_bad = 0, cap_n = 0;
    logic [15:0] cap_word = '0;

    always @(negedge clk) begin
      if (sclk_s[i] && !p_sclk) begin
        cap_word = {cap_word[14:0], sdo_s[i]};
        cap_n++;
        pulse_run++;
      end
      if (sclk_s[i] && (sdo_s[i] !== p_sdo)) sdo_bad++;
      if (!cs_s[i]) low_run++;
      else high_run++;
      if (cs_s[i] && !p_cs) begin
        last_cs_low = low_run; low_run = 0; last_pulses = pulse_run; frames++;
      end
      if (!cs_s[i] && p_cs) begin
        last_cs_high = high_run; high_run = 0; pulse_run = 0;
      end
      if (busy_s[i]) busy_run++;
      if (!busy_s[i] && p_busy) begin
        last_busy = busy_run; busy_run = 0;
      end
      if (done_s[i]) begin
        done_cnt++;
        if (cs_s[i] && !p_cs) done_ok++;
      end
      p_cs = cs_s[i]; p_sclk = sclk_s[i]; p_sdo = sdo_s[i]; p_busy = busy_s[i];
    end
  end

  // Reference model: frame content and timing from the protocol rules.
  function automatic logic [15:0] frame_of(input logic [7:0] v);
`ifdef DAC_SPI_CTRL_EN
    return {CTRL, v, 4'b0000};
`else
    return {8'h00, v};
`endif
  endfunction

  function automatic int exp_cs_low(input int d);
    return BITS * 2 * d + d;
  endfunction

  function automatic logic [15:0] bits_mask(input logic [15:0] w);
    return w & 16'((32'd1 << BITS) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_bits;
  } vec_t;

  task automatic run_frame0(input logic [7:0] v, input bit poke, input string tag);
    int b_cap, b_done, b_ok, n;
    b_cap  = g_lane[0].cap_n;
    b_done = g_lane[0].done_cnt;
    b_ok   = g_lane[0].done_ok;
    @(negedge clk);
    dato_s[0]  = v;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    dato_s[0]  = ~v;
    n = 1;
    while (busy_s[0] !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (poke) start_s[0] = (n == 10 || n == 20);
    end
    start_s[0] = 1'b0;
    check({tag, "_timeout"}, 32'(n < 2000), 32'd1);
    @(negedge clk);
    check({tag, "_nbits"}, 32'(g_lane[0].cap_n - b_cap), 32'(BITS));
    check({tag, "_bits"}, 32'(bits_mask(g_lane[0].cap_word)), 32'(frame_of(v)));
    check({tag, "_cs_low"}, 32'(g_lane[0].last_cs_low), 32'(exp_cs_low(4)));
    check({tag, "_busy_len"}, 32'(g_lane[0].last_busy), 32'(exp_cs_low(4) + 4 + 1));
    check({tag, "_done_cnt"}, 32'(g_lane[0].done_cnt - b_done), 32'd1);
    check({tag, "_done_at_cs_rise"}, 32'(g_lane[0].done_ok - b_ok), 32'd1);
  endtask

  vec_t vecs [5];

  initial begin
    int b_fr, b_done, n, bad;
    logic [7:0] v;

    vecs[0] = '{8'hA5, 8'b1010_0101};
    vecs[1] = '{8'h00, 8'b0000_0000};
    vecs[2] = '{8'hFF, 8'b1111_1111};
    vecs[3] = '{8'h80, 8'b1000_0000};
    vecs[4] = '{8'h01, 8'b0000_0001};

    for (int i = 0; i < 2; i++) begin
      rst_n_s[i] = 1'b0; start_s[i] = 1'b0; dato_s[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs_s[0]), 32'd1);
    check("rst_sclk", 32'(sclk_s[0]), 32'd0);
    check("rst_sdo", 32'(sdo_s[0]), 32'd0);
    check("rst_busy", 32'(busy_s[0]), 32'd0);
    check("rst_done", 32'(done_s[0]), 32'd0);
    check("rst_lane1", 32'({cs_s[1], sclk_s[1], sdo_s[1], busy_s[1], done_s[1]}), 32'b10000);
    rst_n_s[0] = 1'b1; rst_n_s[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Table: hand-written expected data bits, wrapped by the control field when enabled.
    for (int k = 0; k < 5; k++) begin
      run_frame0(vecs[k].din, 1'b0, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_table", k), 32'(bits_mask(g_lane[0].cap_word)),
            32'(frame_of(vecs[k].exp_bits)));
    end

    // start pulses mid-frame must not queue a second frame
    b_fr = g_lane[0].frames;
    run_frame0(8'h3C, 1'b1, "poke");
    repeat (20) @(negedge clk);
    check("poke_frames", 32'(g_lane[0].frames - b_fr), 32'd1);

    for (int k = 0; k < 8; k++) begin
      v = 8'($urandom_range(0, 255));
      run_frame0(v, 1'b0, $sformatf("rnd%0d", k));
    end

    // Back-to-back frames at CLK_DIV=1 with start held high
    b_fr = g_lane[1].frames;
    v = 8'($urandom_range(0, 255));
    @(negedge clk);
    dato_s[1] = v; start_s[1] = 1'b1;
    n = 0;
    while (g_lane[1].frames < b_fr + 3 && n < 1000) begin
      @(negedge clk); n++;
    end
    check("b2b_timeout", 32'(n < 1000), 32'd1);
    check("b2b_gap", 32'(g_lane[1].last_cs_high), 32'd2);
    check("b2b_pulses", 32'(g_lane[1].last_pulses), 32'(BITS));
    check("b2b_cs_low", 32'(g_lane[1].last_cs_low), 32'(exp_cs_low(1)));
    check("b2b_bits", 32'(bits_mask(g_lane[1].cap_word)), 32'(frame_of(v)));
    start_s[1] = 1'b0;
    n = 0;
    while (busy_s[1] !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("b2b_idle", 32'(busy_s[1]), 32'd0);

    // Asynchronous reset in the high phase of bit 3
    b_done = g_lane[0].done_cnt;
    @(negedge clk);
    dato_s[0] = 8'hFF; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (29) @(negedge clk);
    rst_n_s[0] = 1'b0;
    #1;
    check("amid_outputs", 32'({cs_s[0], sclk_s[0], sdo_s[0], busy_s[0], done_s[0]}), 32'b10000);
    repeat (3) @(negedge clk);
    rst_n_s[0] = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cs_s[0] !== 1'b1) bad++;
    end
    check("post_rst_cs_high", 32'(bad), 32'd0);
    check("rst_no_done", 32'(g_lane[0].done_cnt - b_done), 32'd0);
    run_frame0(8'h5A, 1'b0, "post_rst");

    check("sdo_stable_l0", 32'(g_lane[0].sdo_bad), 32'd0);
    check("sdo_stable_l1", 32'(g_lane[1].sdo_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
